// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scanner.
package seg7_pkg;

  localparam int N_DIGITS = 8;
  localparam int DIGIT_W  = 4;

  localparam logic [N_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

endpackage

// File: rtl/seg7_scan_decoder.sv
// Hex nibble to seven-segment pattern, active-low segments, y = {g,f,e,d,c,b,a}.
module decoder (
  input  logic [3:0] x,
  output logic [6:0] y
);

  always_comb begin
    y = 7'h7F;
    case (x)
      4'h0: y = 7'h40;
      4'h1: y = 7'h79;
      4'h2: y = 7'h24;
      4'h3: y = 7'h30;
      4'h4: y = 7'h19;
      4'h5: y = 7'h12;
      4'h6: y = 7'h02;
      4'h7: y = 7'h78;
      4'h8: y = 7'h00;
      4'h9: y = 7'h10;
      4'hA: y = 7'h08;
      4'hB: y = 7'h03;
      4'hC: y = 7'h46;
      4'hD: y = 7'h21;
      4'hE: y = 7'h06;
      4'hF: y = 7'h0E;
      default: y = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit seven-segment scanner with per-slot blanking gap
// and a per-frame snapshot of the digit data and masks.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_DIGITS*DIGIT_W-1:0]   data,
  input  logic [N_DIGITS-1:0]           digit_en,
  input  logic [N_DIGITS-1:0]           dot_en,
  output logic [N_DIGITS-1:0]           AN,
  output logic [6:0]                    HEX,
  output logic                          DP
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
  localparam phase_t PH_RST = (BLANK_CYCLES == 0) ? PH_SHOW : PH_BLANK;

  logic [CNT_W-1:0]              r_cnt;
  logic [IDX_W-1:0]              r_idx;
  phase_t                        r_phase;
  logic [N_DIGITS*DIGIT_W-1:0]   r_data_s;
  logic [N_DIGITS-1:0]           r_en_s;
  logic [N_DIGITS-1:0]           r_dot_s;
  logic [N_DIGITS-1:0]           r_an;
  logic [6:0]                    r_hex;
  logic                          r_dp;

  logic                          w_snap;
  logic                          w_cnt_wrap;
  logic [CNT_W-1:0]              w_cnt_next;
  phase_t                        w_phase_next;
  logic [N_DIGITS*DIGIT_W-1:0]   w_data_eff;
  logic [N_DIGITS-1:0]           w_en_eff;
  logic [N_DIGITS-1:0]           w_dot_eff;
  logic [DIGIT_W-1:0]            w_nib [N_DIGITS];
  logic [DIGIT_W-1:0]            w_dec_in;
  logic [6:0]                    w_seg;
  logic                          w_lit;

  // On the snapshot cycle the shadows are still being loaded, so the live
  // inputs are used directly to keep the whole frame on one sample.
  assign w_snap     = (r_cnt == '0) && (r_idx == '0);
  assign w_data_eff = w_snap ? data     : r_data_s;
  assign w_en_eff   = w_snap ? digit_en : r_en_s;
  assign w_dot_eff  = w_snap ? dot_en   : r_dot_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = w_data_eff[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  // Forcing nibble 0 under reset gives the decoder(0) reset value on HEX.
  assign w_dec_in = rst ? '0 : w_nib[r_idx];

  decoder u_decoder (
    .x (w_dec_in),
    .y (w_seg)
  );

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_cnt_wrap ? '0 : r_cnt + 1'b1;
  assign w_lit      = (r_phase == PH_SHOW) && w_en_eff[r_idx];

  always_comb begin
    w_phase_next = PH_SHOW;
    if (BLANK_CYCLES != 0 && w_cnt_next < BLANK_C) begin
      w_phase_next = PH_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_phase  <= PH_RST;
      r_data_s <= '0;
      r_en_s   <= '0;
      r_dot_s  <= '0;
      r_an     <= AN_OFF;
      r_dp     <= 1'b1;
      r_hex    <= w_seg;
    end else begin
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
      if (w_cnt_wrap) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_snap) begin
        r_data_s <= data;
        r_en_s   <= digit_en;
        r_dot_s  <= dot_en;
      end
      r_hex <= w_seg;
      r_an  <= w_lit ? ~(N_DIGITS'(1) << r_idx) : AN_OFF;
      r_dp  <= w_lit ? ~w_dot_eff[r_idx] : 1'b1;
    end
  end

  assign AN  = r_an;
  assign HEX = r_hex;
  assign DP  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected outputs are predicted from the
// cycle number since reset and the inputs sampled at each frame start.
module tb_seg7_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  dot_en;
  logic [7:0]  AN;
  logic [6:0]  HEX;
  logic        DP;

  typedef struct {
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;
    logic       chk_hex;
    int         slot_start;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          c = 0;
  logic [31:0] m_data_s;
  logic [7:0]  m_en_s;
  logic [7:0]  m_dot_s;
  logic [6:0]  seg_tab [16];

  seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .digit_en (digit_en),
    .dot_en   (dot_en),
    .AN       (AN),
    .HEX      (HEX),
    .DP       (DP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  // Push the prediction for the coming edge, clock it, then compare.
  task automatic step();
    exp_t e;
    int   cnt, idx;
    if (rst) begin
      e.an = 8'hFF; e.dp = 1'b1; e.hex = seg_tab[0]; e.chk_hex = 1'b1; e.slot_start = -1;
      m_data_s = '0; m_en_s = '0; m_dot_s = '0;
    end else begin
      if (c % (8*RD) == 0) begin
        m_data_s = data; m_en_s = digit_en; m_dot_s = dot_en;
      end
      cnt = c % RD;
      idx = (c / RD) % 8;
      e.hex = seg_tab[m_data_s[idx*4 +: 4]];
      e.slot_start = (cnt == BC) ? idx : -1;
      if (cnt >= BC && m_en_s[idx]) begin
        e.an = ~(8'h01 << idx); e.dp = ~m_dot_s[idx]; e.chk_hex = 1'b1;
      end else begin
        e.an = 8'hFF; e.dp = 1'b1; e.chk_hex = 1'b0;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) c = 0; else c++;
    e = sb_q.pop_front();
    check("an", AN, e.an);
    check("dp", DP, e.dp);
    if (e.chk_hex) check("hex", HEX, e.hex);
    check("an_onehot", ($countones(~AN) <= 1), 1);
    if (e.slot_start >= 0)
      $display("slot %0d: AN=%h HEX=%h DP=%b", e.slot_start, AN, HEX, DP);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int phase);
    int guard = 0;
    while (c % (8*RD) != phase && guard < 200) begin
      step();
      guard++;
    end
    check("run_to_bound", (guard < 200), 1);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_data_s = '0; m_en_s = '0; m_dot_s = '0;
    rst = 1'b1; data = 32'h76543210; digit_en = 8'hFF; dot_en = 8'h00;

    // Reset held for three cycles, then two full frames of plain scanning.
    run(3);
    rst = 1'b0;
    run(2 * 8 * RD);

    // Enable/dot masks, applied mid-frame so they land at the next frame.
    run_to(20);
    digit_en = 8'h05; dot_en = 8'h04;
    run(2 * 8 * RD);

    // Snapshot coherence: data change inside slot 3.
    digit_en = 8'hFF; dot_en = 8'h00; data = 32'h76543210;
    run_to(0);
    run(8 * RD);
    run_to(3 * RD);
    data = 32'hFFFFFFFF;
    run(8 * RD);

    // Reset mid-slot at slot 5, cnt 4.
    data = 32'h76543210;
    run_to(5 * RD + 4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(8 * RD + 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scanner for the board's 8-digit seven-segment display. It sits directly downstream of the per-digit value logic and owns AN, HEX and DP. It accepts eight 4-bit digit codes plus per-digit enable and dot masks, and cycles through the digits at a fixed refresh rate. Each digit code is decoded by the existing `decoder`. A blanking gap at every digit change suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, default 1000: cycles at slot start with all anodes off; may be 0.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `data`  in  32  digit codes; digit i = `data[4i+3:4i]`, digit 0 rightmost.
- `digit_en`  in  8  per-digit enable; 0 blanks that digit's slot.
- `dot_en`  in  8  per-digit decimal-point request, active-high.
- `AN`  out  8  anode select, one-hot active-low.
- `HEX`  out  7  segment pattern from `decoder`.
- `DP`  out  1  decimal point, active-low.

## Operation
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1. Digit index `idx` runs 0..7 and wraps 7→0. `idx` advances when `cnt` = `REFRESH_DIV`-1.
- Phase FSM, two states:
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - SHOW for the remainder of the slot.
  - BLANK is skipped entirely when `BLANK_CYCLES` = 0.
- Frame snapshot: `data`, `digit_en` and `dot_en` are latched into shadow registers on the cycle `cnt` = 0 and `idx` = 0 (first cycle after reset included). The whole 8-digit frame is therefore displayed from one consistent sample. Input changes mid-frame take effect at the next frame start.
- SHOW with `digit_en_s[idx]`=1:
  - `AN` = ~(1<<idx).
  - `HEX` = decoder(`data_s[idx]`).
  - `DP` = ~`dot_en_s[idx]`.
- SHOW with `digit_en_s[idx]`=0: `AN` = 8'hFF, `DP` = 1. `HEX` is don't-care but held at the decoded value.
- BLANK: `AN` = 8'hFF, `DP` = 1.
- Nothing is ever driven for a slot other than `idx`. At most one `AN` bit is low at any time.

## Timing
- All outputs are registered. Reset values: `AN` = 8'hFF, `DP` = 1, `HEX` = decoder(4'h0) registered, `cnt` = 0, `idx` = 0, shadows = 0. The FSM resets to BLANK, or to SHOW if `BLANK_CYCLES` = 0.
- Output latency is 1 cycle. Outputs on cycle n+1 reflect `cnt`/`idx` on cycle n.
- First lit digit after reset deasserts: `AN[0]` goes low on cycle `BLANK_CYCLES`+1 after `rst` falls, provided `digit_en[0]` was 1 at the snapshot.
- Slot period is exactly `REFRESH_DIV` cycles. Frame period is 8·`REFRESH_DIV`.
- Simultaneous snapshot and index wrap: the wrap to `idx` = 0 happens first, then the snapshot is taken on the following cycle (`cnt` = 0).
- `rst` mid-slot: on the next edge, all state returns to reset values and `AN` = 8'hFF. There is no partial-slot carry-over.

## Structure
- Shared package `seg7_pkg`:
  - constants `N_DIGITS` = 8, `DIGIT_W` = 4;
  - typedef for the phase enum (BLANK, SHOW);
  - constant `AN_OFF` = 8'hFF.
- One sub-module: the existing `decoder` (x[3:0] → y[6:0]), instantiated once on the muxed nibble. It is not duplicated per digit.
- Counter, FSM, shadow registers and output registers all live in `seg7_scan`.

## Test plan
All scenarios use `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset: hold `rst` 3 cycles → `AN`=8'hFF, `DP`=1 throughout. After release, `AN`=8'hFE first appears on cycle 3 and holds 6 cycles.
- Scan order: `data`=32'h76543210, `digit_en`=8'hFF → `AN` walks FE,FD,FB,…,7F. Each slot shows 2 blank + 6 lit cycles. `HEX` = decoder(i) in slot i. The pattern repeats every 64 cycles.
- Masks: `digit_en`=8'h05, `dot_en`=8'h04 → only slots 0 and 2 light. `DP`=0 only during slot 2 SHOW.
- Snapshot coherence: change `data` to 32'hFFFFFFFF at slot 3 → slots 3..7 still show 3..7. Slot 0 of the next frame shows F.
- Reset mid-slot: assert `rst` at slot 5, `cnt`=4 → next cycle `AN`=8'hFF. The scan restarts at slot 0 with a full blank gap.
- Invariant (assertion, all scenarios): at most one `AN` bit is low at any time.
